// File: rtl/rv32i_pc_pkg.sv
// Shared types and default constants for the RV32I fetch PC generator.
package rv32i_pc_pkg;

    // Two-state fetch FSM: one dead cycle after reset, then continuous issue.
    typedef enum logic [0:0] {
        StBoot = 1'b0,
        StRun  = 1'b1
    } pc_state_e;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;
    localparam int unsigned DEFAULT_PC_STEP      = 4;

    // Low address bits that must be clear for a legal 32-bit instruction fetch.
    localparam logic [1:0] MISALIGN_MASK = 2'b11;

    function automatic logic is_misaligned(input logic [1:0] low_bits);
        return (low_bits & MISALIGN_MASK) != 2'b00;
    endfunction

endpackage

// File: rtl/rv32i_redir_arb.sv
// Fixed-priority arbiter over redirect channels; channel 0 wins.
module rv32i_redir_arb #(
    parameter int unsigned NUM_REDIR = 4,
    parameter int unsigned XLEN      = 32,
    parameter int unsigned IDX_W     = (NUM_REDIR > 1) ? $clog2(NUM_REDIR) : 1
) (
    input  logic [NUM_REDIR-1:0]      redir_valid,
    input  logic [NUM_REDIR*XLEN-1:0] redir_target,
    output logic                      any_valid,
    output logic [IDX_W-1:0]          sel_idx,
    output logic [XLEN-1:0]           sel_target
);

    // Scan from the lowest-priority channel upward so the lowest requesting index is kept last.
    always_comb begin
        any_valid  = 1'b0;
        sel_idx    = '0;
        sel_target = '0;
        for (int i = NUM_REDIR - 1; i >= 0; i--) begin
            if (redir_valid[i]) begin
                any_valid  = 1'b1;
                sel_idx    = IDX_W'(i);
                sel_target = redir_target[i*XLEN +: XLEN];
            end
        end
    end

endmodule

// File: rtl/rv32i_pc_gen.sv
// Fetch PC register and next-PC selection with prioritised redirects and
// misaligned-target trapping.
module rv32i_pc_gen
    import rv32i_pc_pkg::*;
#(
    parameter int unsigned     XLEN         = 32,
    parameter int unsigned     NUM_REDIR    = 4,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(DEFAULT_TRAP_VECTOR),
    parameter int unsigned     PC_STEP      = DEFAULT_PC_STEP
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REDIR-1:0]      redir_valid,
    input  logic [NUM_REDIR*XLEN-1:0] redir_target,
    input  logic                      fetch_ready,
    output logic                      fetch_valid,
    output logic [XLEN-1:0]           fetch_pc,
    output logic                      redir_taken,
    output logic                      misalign_valid,
    output logic [XLEN-1:0]           misalign_addr
);

    localparam int unsigned IDX_W = (NUM_REDIR > 1) ? $clog2(NUM_REDIR) : 1;

    pc_state_e        state_q;
    logic             any_redir;
    logic [IDX_W-1:0] sel_idx;
    logic [XLEN-1:0]  sel_target;
    logic             sel_misaligned;

    rv32i_redir_arb #(
        .NUM_REDIR (NUM_REDIR),
        .XLEN      (XLEN),
        .IDX_W     (IDX_W)
    ) u_arb (
        .redir_valid  (redir_valid),
        .redir_target (redir_target),
        .any_valid    (any_redir),
        .sel_idx      (sel_idx),
        .sel_target   (sel_target)
    );

    assign sel_misaligned = is_misaligned(sel_target[1:0]);

    // The arbiter must only ever pick a channel that is actually requesting.
    always_comb begin
        if (any_redir) begin
            assert (redir_valid[sel_idx]);
        end
    end

    // FSM, PC register and registered status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StBoot;
            fetch_valid    <= 1'b0;
            fetch_pc       <= RESET_VECTOR;
            redir_taken    <= 1'b0;
            misalign_valid <= 1'b0;
            misalign_addr  <= '0;
        end else begin
            redir_taken    <= any_redir;
            misalign_valid <= any_redir && sel_misaligned;

            // A redirect flushes any un-accepted fetch, so it outranks the handshake.
            if (any_redir) begin
                if (sel_misaligned) begin
                    fetch_pc      <= TRAP_VECTOR;
                    misalign_addr <= sel_target;
                end else begin
                    fetch_pc <= sel_target;
                end
            end else if (fetch_valid && fetch_ready) begin
                fetch_pc <= fetch_pc + XLEN'(PC_STEP);
            end

            case (state_q)
                StBoot: begin
                    state_q     <= StRun;
                    fetch_valid <= 1'b1;
                end
                StRun: begin
                    state_q     <= StRun;
                    fetch_valid <= 1'b1;
                end
                default: begin
                    state_q     <= StBoot;
                    fetch_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
